// File: rtl/outport_arbiter_if.sv
// outport_arbiter_if: request/tail/grant bundle between flow control, arbiter and crossbar
//   Lreq/Nreq/Ereq    per-input request (flit waiting and output FIFO ready)
//   Ltail/Ntail/Etail per-input tail flag of the presented flit
//   Lgrant/Ngrant/Egrant registered one-hot grant (crossbar select, FIFO read enables)
//   busy              arbiter holds a lock
//   xfer              a flit moves this cycle
//   modport master: request side (flow control); modport slave: the arbiter
interface outport_arbiter_if;
    logic Lreq, Nreq, Ereq;
    logic Ltail, Ntail, Etail;
    logic Lgrant, Ngrant, Egrant;
    logic busy;
    logic xfer;
    modport master (
        output Lreq, Nreq, Ereq, Ltail, Ntail, Etail,
        input  Lgrant, Ngrant, Egrant, busy, xfer
    );
    modport slave (
        input  Lreq, Nreq, Ereq, Ltail, Ntail, Etail,
        output Lgrant, Ngrant, Egrant, busy, xfer
    );
endinterface

// File: rtl/outport_arbiter.sv
// outport_arbiter: round-robin, packet-locking arbiter for one output of a 3-port (L, N, E) router
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  outport_arbiter_if.slave: requests/tails in, one-hot grant, busy and xfer out
//   ARB_LOCK_TIMEOUT_EN: when defined, a lock stalled for TIMEOUT cycles is released
//   TIMEOUT: stall limit in cycles; TW: stall counter width, 2**TW > TIMEOUT
module outport_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input logic         clk,
    input logic         rst,
    outport_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOCK_L, LOCK_N, LOCK_E} state_t;
    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt, own, own_succ, win;
    logic [2:0]  req, tail, grant;
    logic        release_lock, tmo;

    if (2**TW <= TIMEOUT) begin : g_bad_tw
        $error("outport_arbiter: TW too narrow for TIMEOUT");
    end

    function automatic logic [1:0] succ(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    // first requester in cyclic order L->N->E starting at s
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] s);
        logic [1:0] s1, s2;
        s1 = succ(s);
        s2 = succ(s1);
        return r[s] ? s : r[s1] ? s1 : s2;
    endfunction

    assign req      = {bus.Ereq, bus.Nreq, bus.Lreq};
    assign tail     = {bus.Etail, bus.Ntail, bus.Ltail};
    assign grant    = {state == LOCK_E, state == LOCK_N, state == LOCK_L};
    assign {bus.Egrant, bus.Ngrant, bus.Lgrant} = grant;
    assign bus.busy = state != IDLE;
    assign bus.xfer = |(grant & req);

    // LOCK_x encodes owner index + 1
    assign own          = state - 2'd1;
    assign own_succ     = succ(own);
    assign release_lock = bus.busy & ((|(grant & req & tail)) | tmo);
    // on release the old owner is searched last, so it wins only when alone
    assign win          = pick(req, bus.busy ? own_succ : ptr);

    always_comb begin
        state_nxt = (!bus.busy || release_lock) ? (|req ? state_t'(win + 2'd1) : IDLE) : state;
        ptr_nxt   = release_lock ? own_succ : ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    logic [TW-1:0] cnt;

    // cnt counts earlier stalled cycles; the TIMEOUT-th consecutive stall releases at its edge
    assign tmo = bus.busy & ~bus.xfer & (cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= (!bus.busy || bus.xfer || release_lock) ? '0 : cnt + TW'(1);
    end
`else
    assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_outport_arbiter.sv
// tb_outport_arbiter: directed and randomized checks of outport_arbiter against a behavioural model
module tb_outport_arbiter;
    localparam int TIMEOUT = 15;
    localparam int TW      = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req  = 3'b000;
    logic [2:0] tail = 3'b000;
    logic [2:0] gnt;

    int total = 0;
    int pass  = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_stall = 0;

    outport_arbiter_if bus ();

    assign bus.Lreq  = req[0];
    assign bus.Nreq  = req[1];
    assign bus.Ereq  = req[2];
    assign bus.Ltail = tail[0];
    assign bus.Ntail = tail[1];
    assign bus.Etail = tail[2];
    assign gnt = {bus.Egrant, bus.Ngrant, bus.Lgrant};

    outport_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic int first_from(input logic [2:0] r, input int s);
        for (int k = 0; k < 3; k++)
            if (r[(s + k) % 3]) return (s + k) % 3;
        return -1;
    endfunction

    function automatic int onehot(input int o);
        return o < 0 ? 0 : (1 << o);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // behavioural model: who owns the output, who has priority, how long the owner stalled
    initial begin
        bit moved, rel;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_owner = -1;
                m_ptr   = 0;
                m_stall = 0;
            end else if (m_owner < 0) begin
                m_owner = first_from(req, m_ptr);
                m_stall = 0;
            end else begin
                moved   = req[m_owner];
                rel     = moved && tail[m_owner];
                m_stall = moved ? 0 : m_stall + 1;
`ifdef ARB_LOCK_TIMEOUT_EN
                if (m_stall == TIMEOUT) rel = 1'b1;
`endif
                if (rel) begin
                    m_ptr   = (m_owner + 1) % 3;
                    m_owner = first_from(req, m_ptr);
                    m_stall = 0;
                end
            end
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("model_grant", int'(gnt), onehot(m_owner));
            chk("model_busy", int'(bus.busy), int'(m_owner >= 0));
            chk("model_xfer", int'(bus.xfer), int'(m_owner >= 0 && req[m_owner]));
        end
    end

    initial begin
        int flits [3];
        // reset, then idle
        repeat (2) step();
        rst = 1'b0;
        #1 chk("reset_grant", int'(gnt), 0);
        chk("reset_busy", int'(bus.busy), 0);
        repeat (10) step();
        #1 chk("idle_grant", int'(gnt), 0);
        chk("idle_busy", int'(bus.busy), 0);

        // contention with 3-flit packets
        req = 3'b111;
        tail = 3'b000;
        flits = '{0, 0, 0};
        step();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 3; i++) tail[i] = (flits[i] % 3 == 2);
            #1 chk($sformatf("contention_grant_%0d", k), int'(gnt), 1 << ((k / 3) % 3));
            chk($sformatf("contention_xfer_%0d", k), int'(bus.xfer), 1);
            for (int i = 0; i < 3; i++) if (gnt[i] && req[i]) flits[i]++;
            step();
        end
        rst = 1'b1;
        #1 chk("contention_rst_grant", int'(gnt), 0);
        step();
        rst = 1'b0;

        // lock under stall, then reset mid-packet
        req = 3'b010;
        tail = 3'b000;
        step();
        #1 chk("stall_n_granted", int'(gnt), 3'b010);
        step();
        req = 3'b101;
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("stall_grant_%0d", k), int'(gnt), 3'b010);
            chk($sformatf("stall_xfer_%0d", k), int'(bus.xfer), 0);
            step();
        end
        #1 rst = 1'b1;
        #1 chk("rst_lock_n_grant", int'(gnt), 0);
        chk("rst_lock_n_busy", int'(bus.busy), 0);
        chk("rst_lock_n_xfer", int'(bus.xfer), 0);
        step();
        rst = 1'b0;
        req = 3'b111;
        step();
        #1 chk("rst_ptr_is_l", int'(gnt), 3'b001);
        req = 3'b000;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // single-flit packets from E, then L joins
        req = 3'b100;
        tail = 3'b100;
        step();
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("single_e_grant_%0d", k), int'(gnt), 3'b100);
            chk($sformatf("single_e_xfer_%0d", k), int'(bus.xfer), 1);
            step();
        end
        req = 3'b101;
        #1 chk("single_e_before_l", int'(gnt), 3'b100);
        step();
        #1 chk("single_l_after_tail", int'(gnt), 3'b001);
        req = 3'b000;
        tail = 3'b000;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // stalled lock with another requester waiting
        req = 3'b001;
        step();
        req = 3'b010;
`ifdef ARB_LOCK_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT; k++) begin
            #1 chk($sformatf("timeout_hold_%0d", k), int'(gnt), 3'b001);
            step();
        end
        #1 chk("timeout_release_n", int'(gnt), 3'b010);
`else
        for (int k = 0; k < 100; k++) begin
            #1 chk($sformatf("no_timeout_hold_%0d", k), int'(gnt), 3'b001);
            step();
        end
`endif
        req = 3'b000;
        rst = 1'b1;
        step();
        rst = 1'b0;

        // randomized traffic, checked every cycle by the model
        for (int k = 0; k < 10000; k++) begin
            req = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) tail[i] = ($urandom_range(0, 3) == 0);
            step();
        end

        @(negedge clk);
        #1 $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
